// File: rtl/arp_req_arb.sv
// Round-robin arbiter sharing one ARP cache lookup channel among PORTS requesters.
// Latency: grant one cycle after request; response routed one cycle after cache reply; all outputs registered.
// Backpressure: one lookup outstanding; valids held until handshake, timeout synthesises an error reply.
module arp_req_arb #(
    parameter int PORTS   = 2,
    parameter int TIMEOUT = 65535,
    parameter int IDX_W   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [PORTS-1:0]      s_arp_request_valid,
    output logic [PORTS-1:0]      s_arp_request_ready,
    input  logic [PORTS*32-1:0]   s_arp_request_ip,
    output logic [PORTS-1:0]      s_arp_response_valid,
    input  logic [PORTS-1:0]      s_arp_response_ready,
    output logic                  s_arp_response_error,
    output logic [47:0]           s_arp_response_mac,

    output logic                  m_arp_request_valid,
    input  logic                  m_arp_request_ready,
    output logic [31:0]           m_arp_request_ip,
    input  logic                  m_arp_response_valid,
    output logic                  m_arp_response_ready,
    input  logic                  m_arp_response_error,
    input  logic [47:0]           m_arp_response_mac,

    output logic [IDX_W-1:0]      grant_index,
    output logic                  busy,
    output logic                  timeout_event
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_RESPONSE,
        ST_RETURN
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  tmo_cnt;

    logic              found;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;

    // First requester at or after rr_ptr, wrapping modulo PORTS.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < PORTS; k++) begin
            cand = (int'(rr_ptr) + k >= PORTS) ? IDX_W'(int'(rr_ptr) + k - PORTS)
                                               : IDX_W'(int'(rr_ptr) + k);
            if (!found && s_arp_request_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            rr_ptr               <= '0;
            grant_index          <= '0;
            tmo_cnt              <= '0;
            s_arp_request_ready  <= '0;
            s_arp_response_valid <= '0;
            s_arp_response_error <= 1'b0;
            s_arp_response_mac   <= '0;
            m_arp_request_valid  <= 1'b0;
            m_arp_request_ip     <= '0;
            m_arp_response_ready <= 1'b0;
            busy                 <= 1'b0;
            timeout_event        <= 1'b0;
        end else begin
            s_arp_request_ready <= '0;
            timeout_event       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_index          <= pick;
                        m_arp_request_ip     <= s_arp_request_ip[32*pick +: 32];
                        m_arp_request_valid  <= 1'b1;
                        s_arp_request_ready  <= PORTS'(1) << pick;
                        m_arp_response_ready <= 1'b0;
                        busy                 <= 1'b1;
                        state                <= ST_REQUEST;
                    end else begin
                        // Stale replies are swallowed while idle.
                        m_arp_response_ready <= 1'b1;
                    end
                end
                ST_REQUEST: begin
                    if (m_arp_request_valid && m_arp_request_ready) begin
                        m_arp_request_valid  <= 1'b0;
                        m_arp_response_ready <= 1'b1;
                        tmo_cnt              <= '0;
                        state                <= ST_RESPONSE;
                    end
                end
                ST_RESPONSE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (m_arp_response_valid && m_arp_response_ready) begin
                        s_arp_response_mac   <= m_arp_response_mac;
                        s_arp_response_error <= m_arp_response_error;
                        s_arp_response_valid <= PORTS'(1) << grant_index;
                        m_arp_response_ready <= 1'b0;
                        state                <= ST_RETURN;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        s_arp_response_mac   <= '0;
                        s_arp_response_error <= 1'b1;
                        s_arp_response_valid <= PORTS'(1) << grant_index;
                        m_arp_response_ready <= 1'b0;
                        timeout_event        <= 1'b1;
                        state                <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    // Drain late replies from a timed-out lookup.
                    m_arp_response_ready <= 1'b1;
                    if (s_arp_response_valid[grant_index] && s_arp_response_ready[grant_index]) begin
                        s_arp_response_valid <= '0;
                        rr_ptr               <= (grant_index == IDX_W'(PORTS - 1)) ? '0
                                                : grant_index + 1'b1;
                        busy                 <= 1'b0;
                        state                <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arp_req_arb.sv
// Directed bench for arp_req_arb (PORTS=2, TIMEOUT=16) with hand-computed expectations.
module tb_arp_req_arb;

    localparam int PORTS = 2;
    localparam int IDX_W = 1;

    logic               clk;
    logic               rst_n;
    logic [PORTS-1:0]   s_arp_request_valid;
    logic [PORTS-1:0]   s_arp_request_ready;
    logic [63:0]        s_arp_request_ip;
    logic [PORTS-1:0]   s_arp_response_valid;
    logic [PORTS-1:0]   s_arp_response_ready;
    logic               s_arp_response_error;
    logic [47:0]        s_arp_response_mac;
    logic               m_arp_request_valid;
    logic               m_arp_request_ready;
    logic [31:0]        m_arp_request_ip;
    logic               m_arp_response_valid;
    logic               m_arp_response_ready;
    logic               m_arp_response_error;
    logic [47:0]        m_arp_response_mac;
    logic [IDX_W-1:0]   grant_index;
    logic               busy;
    logic               timeout_event;

    int checks   = 0;
    int failures = 0;

    arp_req_arb #(.PORTS(PORTS), .TIMEOUT(16)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s_arp_request_valid  (s_arp_request_valid),
        .s_arp_request_ready  (s_arp_request_ready),
        .s_arp_request_ip     (s_arp_request_ip),
        .s_arp_response_valid (s_arp_response_valid),
        .s_arp_response_ready (s_arp_response_ready),
        .s_arp_response_error (s_arp_response_error),
        .s_arp_response_mac   (s_arp_response_mac),
        .m_arp_request_valid  (m_arp_request_valid),
        .m_arp_request_ready  (m_arp_request_ready),
        .m_arp_request_ip     (m_arp_request_ip),
        .m_arp_response_valid (m_arp_response_valid),
        .m_arp_response_ready (m_arp_response_ready),
        .m_arp_response_error (m_arp_response_error),
        .m_arp_response_mac   (m_arp_response_mac),
        .grant_index          (grant_index),
        .busy                 (busy),
        .timeout_event        (timeout_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n                = 1'b0;
        s_arp_request_valid  = '0;
        s_arp_request_ip     = '0;
        s_arp_response_ready = '0;
        m_arp_request_ready  = 1'b0;
        m_arp_response_valid = 1'b0;
        m_arp_response_error = 1'b0;
        m_arp_response_mac   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    int n_grants;
    logic [31:0] ip_tab [2];

    initial begin
        ip_tab[0] = 32'hC0A8_0001;
        ip_tab[1] = 32'hC0A8_0002;

        // Reset values
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_req_valid",  64'(m_arp_request_valid),  64'(0));
        chk("rst_s_req_ready",  64'(s_arp_request_ready),  64'(0));
        chk("rst_s_resp_valid", 64'(s_arp_response_valid), 64'(0));
        chk("rst_m_resp_ready", 64'(m_arp_response_ready), 64'(0));
        chk("rst_busy",         64'(busy),                 64'(0));
        chk("rst_grant",        64'(grant_index),          64'(0));
        chk("rst_m_ip",         64'(m_arp_request_ip),     64'(0));
        chk("rst_mac",          64'(s_arp_response_mac),   64'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("idle_m_resp_ready", 64'(m_arp_response_ready), 64'(1));

        // Single request from port 0
        m_arp_request_ready  = 1'b1;
        s_arp_response_ready = 2'b11;
        s_arp_request_ip     = {32'h0, 32'h0A00_0002};
        s_arp_request_valid  = 2'b01;
        step();
        chk("single_m_valid", 64'(m_arp_request_valid), 64'(1));
        chk("single_m_ip",    64'(m_arp_request_ip),    64'h0A00_0002);
        chk("single_s_ready", 64'(s_arp_request_ready), 64'(2'b01));
        chk("single_busy",    64'(busy),                64'(1));
        s_arp_request_valid = 2'b00;
        step();
        chk("single_hs_m_valid",    64'(m_arp_request_valid),  64'(0));
        chk("single_hs_resp_ready", 64'(m_arp_response_ready), 64'(1));
        m_arp_response_valid = 1'b1;
        m_arp_response_mac   = 48'h02AA_BBCC_DDEE;
        m_arp_response_error = 1'b0;
        step();
        m_arp_response_valid = 1'b0;
        chk("single_s_resp_valid", 64'(s_arp_response_valid), 64'(2'b01));
        chk("single_mac",          64'(s_arp_response_mac),   64'h02AA_BBCC_DDEE);
        chk("single_err",          64'(s_arp_response_error), 64'(0));
        step();
        chk("single_done_valid", 64'(s_arp_response_valid), 64'(0));
        chk("single_done_busy",  64'(busy),                 64'(0));

        // Contention: both ports request continuously, cache answers at once
        do_reset();
        s_arp_request_ip     = {ip_tab[1], ip_tab[0]};
        s_arp_request_valid  = 2'b11;
        m_arp_request_ready  = 1'b1;
        s_arp_response_ready = 2'b11;
        m_arp_response_valid = 1'b1;
        m_arp_response_mac   = 48'h0000_1111_2222;
        n_grants = 0;
        for (int cyc = 0; cyc < 100 && n_grants < 4; cyc++) begin
            step();
            if (s_arp_request_ready != 2'b00) begin
                chk("cont_grant_idx", 64'(grant_index),         64'(n_grants % 2));
                chk("cont_ip",        64'(m_arp_request_ip),    64'(ip_tab[n_grants % 2]));
                chk("cont_s_ready",   64'(s_arp_request_ready), 64'(2'b01 << (n_grants % 2)));
                n_grants++;
            end
        end
        chk("cont_grant_count", 64'(n_grants), 64'(4));

        // Backpressure on both sides, port 1
        do_reset();
        s_arp_request_ip    = {32'h0A00_00FE, 32'h0};
        s_arp_request_valid = 2'b10;
        step();
        chk("bp_s_ready", 64'(s_arp_request_ready), 64'(2'b10));
        s_arp_request_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_m_valid_hold", 64'(m_arp_request_valid), 64'(1));
            chk("bp_m_ip_hold",    64'(m_arp_request_ip),    64'h0A00_00FE);
        end
        m_arp_request_ready = 1'b1;
        step();
        m_arp_request_ready  = 1'b0;
        m_arp_response_valid = 1'b1;
        m_arp_response_mac   = 48'h1122_3344_5566;
        step();
        m_arp_response_valid = 1'b0;
        m_arp_response_mac   = '0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_resp_valid_hold", 64'(s_arp_response_valid), 64'(2'b10));
            chk("bp_mac_hold",        64'(s_arp_response_mac),   64'h1122_3344_5566);
            step();
        end
        chk("bp_resp_valid_still", 64'(s_arp_response_valid), 64'(2'b10));
        s_arp_response_ready = 2'b10;
        step();
        chk("bp_resp_done", 64'(s_arp_response_valid), 64'(0));

        // Timeout with no cache reply, then a late reply is drained
        do_reset();
        m_arp_request_ready = 1'b1;
        s_arp_request_ip    = {32'h0, 32'h0A00_0063};
        s_arp_request_valid = 2'b01;
        step();
        s_arp_request_valid = 2'b00;
        step();
        for (int i = 0; i < 15; i++) step();
        chk("tmo_not_yet_valid", 64'(s_arp_response_valid), 64'(0));
        chk("tmo_not_yet_event", 64'(timeout_event),        64'(0));
        step();
        chk("tmo_valid", 64'(s_arp_response_valid), 64'(2'b01));
        chk("tmo_err",   64'(s_arp_response_error), 64'(1));
        chk("tmo_mac",   64'(s_arp_response_mac),   64'(0));
        chk("tmo_event", 64'(timeout_event),        64'(1));
        step();
        chk("tmo_event_pulse", 64'(timeout_event),        64'(0));
        chk("tmo_drain_ready", 64'(m_arp_response_ready), 64'(1));
        m_arp_response_valid = 1'b1;
        m_arp_response_mac   = 48'hDEAD_BEEF_0001;
        step();
        m_arp_response_valid = 1'b0;
        chk("tmo_late_valid", 64'(s_arp_response_valid), 64'(2'b01));
        chk("tmo_late_mac",   64'(s_arp_response_mac),   64'(0));
        chk("tmo_late_err",   64'(s_arp_response_error), 64'(1));
        s_arp_response_ready = 2'b01;
        step();
        chk("tmo_back_idle", 64'(busy), 64'(0));

        // Error passthrough on port 1
        do_reset();
        m_arp_request_ready  = 1'b1;
        s_arp_request_ip     = {32'h0A00_0007, 32'h0};
        s_arp_request_valid  = 2'b10;
        step();
        s_arp_request_valid  = 2'b00;
        step();
        m_arp_response_valid = 1'b1;
        m_arp_response_error = 1'b1;
        m_arp_response_mac   = '0;
        step();
        m_arp_response_valid = 1'b0;
        chk("err_valid", 64'(s_arp_response_valid), 64'(2'b10));
        chk("err_flag",  64'(s_arp_response_error), 64'(1));
        chk("err_event", 64'(timeout_event),        64'(0));

        // Reset while waiting for a response, then a fresh port 1 request
        do_reset();
        m_arp_request_ready = 1'b1;
        s_arp_request_ip    = {32'h0A00_0011, 32'h0A00_0010};
        s_arp_request_valid = 2'b01;
        step();
        s_arp_request_valid = 2'b00;
        step();
        chk("mid_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid",    64'(m_arp_request_valid),  64'(0));
        chk("mid_rst_s_ready",    64'(s_arp_request_ready),  64'(0));
        chk("mid_rst_s_resp",     64'(s_arp_response_valid), 64'(0));
        chk("mid_rst_m_resp_rdy", 64'(m_arp_response_ready), 64'(0));
        chk("mid_rst_busy",       64'(busy),                 64'(0));
        step();
        rst_n = 1'b1;
        s_arp_request_valid = 2'b10;
        step();
        chk("post_rst_s_ready", 64'(s_arp_request_ready), 64'(2'b10));
        chk("post_rst_grant",   64'(grant_index),         64'(1));
        chk("post_rst_ip",      64'(m_arp_request_ip),    64'h0A00_0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arp_req_arb.md
Name: arp_req_arb

Overview:
- Shares the single ARP cache request/response channel among PORTS independent requesters. Requesters include the IPv4 TX path and any future IP/RoCE transmit engines.
- One lookup is outstanding at a time. Grant order is round-robin.
- Each returned MAC or error is routed back to the requester that issued the lookup.
- A response timeout synthesises an error response, so a lost lookup cannot deadlock a transmit path.

Parameters:
- PORTS, 2, number of requester ports (1..8).
- TIMEOUT, 65535, maximum cycles spent in RESPONSE before an error is synthesised (>=2).
- IDX_W, $clog2(PORTS) (1 when PORTS=1), width of the grant index.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- s_arp_request_valid  input  PORTS  per-requester lookup request.
- s_arp_request_ready  output  PORTS  per-requester request accept.
- s_arp_request_ip  input  PORTS*32  per-requester IP; requester i occupies bits [32i+31:32i].
- s_arp_response_valid  output  PORTS  per-requester response valid.
- s_arp_response_ready  input  PORTS  per-requester response accept.
- s_arp_response_error  output  1  shared; meaningful only with the asserted valid bit.
- s_arp_response_mac  output  48  shared resolved MAC.
- m_arp_request_valid  output  1  request toward the ARP cache.
- m_arp_request_ready  input  1  ARP cache accepts the request.
- m_arp_request_ip  output  32  registered IP of the granted requester.
- m_arp_response_valid  input  1  ARP cache response valid.
- m_arp_response_ready  output  1  response accept.
- m_arp_response_error  input  1  lookup failed.
- m_arp_response_mac  input  48  resolved MAC.
- grant_index  output  IDX_W  index of the current or last grant.
- busy  output  1  high whenever state is not IDLE.
- timeout_event  output  1  one-cycle pulse when a timeout fires.

Behaviour:
- All outputs are registered.
- States: IDLE, REQUEST, RESPONSE, RETURN.
- Reset (asynchronous assert, synchronous deassert):
  - state=IDLE, rr_ptr=0, grant_index=0, timeout counter=0.
  - All valid, ready and pulse outputs 0; m_arp_request_ip=0; s_arp_response_mac=0; s_arp_response_error=0.
  - Reset during a transaction abandons it silently. Requesters must re-issue.
- IDLE:
  - m_arp_response_ready=1, so stale responses are accepted and discarded.
  - If any s_arp_request_valid bit is high, grant the first set bit at or after rr_ptr, wrapping modulo PORTS.
  - Registered effects of the grant:
    - grant_index=g;
    - m_arp_request_ip=ip[g];
    - m_arp_request_valid=1;
    - s_arp_request_ready[g]=1 for exactly one cycle;
    - go to REQUEST.
  - Latency: request seen at cycle 0 -> m_arp_request_valid and s_arp_request_ready[g] high at cycle 1.
- REQUEST:
  - m_arp_request_valid and m_arp_request_ip held stable until m_arp_request_ready.
  - On the handshake: m_arp_request_valid=0, m_arp_response_ready=1, counter cleared, go to RESPONSE.
  - m_arp_response_ready=0 in this state. No timeout applies here.
- RESPONSE:
  - The counter increments every cycle.
  - On m_arp_response_valid & m_arp_response_ready, register mac and error onto the s_ outputs, set s_arp_response_valid[grant_index]=1, m_arp_response_ready=0, go to RETURN.
  - When the counter reaches TIMEOUT-1 with no response, the same path is taken with error=1 and mac=0, and timeout_event pulses once.
  - Response and timeout on the same cycle: the response wins and timeout_event stays 0.
- RETURN:
  - m_arp_response_ready=1, so late responses from a timed-out lookup are drained.
  - s_arp_response_valid[grant_index] held until s_arp_response_ready[grant_index].
  - On that handshake: valid=0, rr_ptr=(grant_index+1) mod PORTS, go to IDLE.
  - Back-to-back grants are therefore separated by at least one IDLE cycle.
- Round-robin fairness: with all PORTS requesting continuously, each is granted once per PORTS grants.
- A requester dropping valid before it is granted is legal and is not granted.
- At most one bit of s_arp_request_ready and at most one bit of s_arp_response_valid is high in any cycle.
- PORTS=1 degenerates to a pass-through register stage with timeout.

Test Plan:
- Single request: port0 ip=0x0A000002 at cycle 0 -> m_arp_request_valid=1 with ip 0x0A000002 and s_arp_request_ready=2'b01 at cycle 1. Cache responds with mac=0x02AABBCCDDEE, error=0 -> s_arp_response_valid=2'b01 next cycle carrying that MAC.
- Contention: PORTS=2, both ports request every cycle from reset -> grant order 0,1,0,1. m_arp_request_ip alternates between the ports' IPs; no request is lost.
- Backpressure: m_arp_request_ready held 0 for 5 cycles -> valid and ip stable for 5 cycles. Then s_arp_response_ready held 0 for 3 cycles -> s_arp_response_valid and mac stable until accepted.
- Timeout: TIMEOUT=16, no cache response -> after 16 RESPONSE cycles, s_arp_response_error=1, mac=0, one timeout_event pulse. A late response in RETURN/IDLE is consumed and not routed.
- Error passthrough: cache returns error=1 -> granted port sees error=1, timeout_event=0.
- Reset mid-RESPONSE: rst_n low -> all valid/ready outputs 0 immediately, busy=0. After release, a fresh port1 request is granted normally.
